// File: rtl/serial_bcd_xs3_codec.sv
// Bit-serial LSB-first BCD <-> Excess-3 converter with multi-digit word framing.
// Optional invalid-digit detection is enabled by defining SERIAL_BCD_XS3_ERR_EN.
module serial_bcd_xs3_codec #(
  parameter int unsigned DIGITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic mode,
  input  logic b_valid,
  input  logic b_in,
  input  logic frame_clr,
  output logic b_out,
  output logic b_out_valid,
  output logic digit_done,
  output logic word_done,
  output logic digit_err
);

  localparam int unsigned DCNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [DCNT_W-1:0] LAST_DIG = DCNT_W'(DIGITS - 1);

  logic [1:0]        bit_cnt;
  logic [DCNT_W-1:0] dig_cnt;
  logic              cb;
  logic              mode_q;

  logic first_c;
  logic last_c;
  logic mode_eff_c;
  logic k_c;
  logic cin_c;
  logic o_c;
  logic cb_next_c;
  logic err_c;

  // One serial full adder/subtractor against constant 4'b0011.
  always_comb begin
    first_c    = (bit_cnt == 2'd0);
    last_c     = (bit_cnt == 2'd3);
    mode_eff_c = first_c ? mode : mode_q;
    k_c        = ~bit_cnt[1];
    cin_c      = first_c ? 1'b0 : cb;
    o_c        = b_in ^ k_c ^ cin_c;
    if (mode_eff_c)
      cb_next_c = (~b_in & (k_c | cin_c)) | (k_c & cin_c);
    else
      cb_next_c = (b_in & k_c) | (cin_c & (b_in ^ k_c));
  end

`ifdef SERIAL_BCD_XS3_ERR_EN
  logic [2:0] shadow;
  logic [3:0] digit_val_c;

  // Legal BCD is 0..9; legal XS3 is 3..12.
  always_comb begin
    digit_val_c = {b_in, shadow};
    if (mode_q)
      err_c = (digit_val_c < 4'd3) || (digit_val_c > 4'd12);
    else
      err_c = (digit_val_c > 4'd9);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow <= 3'b000;
    end else if (b_valid && !frame_clr) begin
      case (bit_cnt)
        2'd0:    shadow[0] <= b_in;
        2'd1:    shadow[1] <= b_in;
        2'd2:    shadow[2] <= b_in;
        default: shadow    <= shadow;
      endcase
    end
  end
`else
  always_comb err_c = 1'b0;
`endif

  // Position counters, carry/borrow and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt     <= 2'd0;
      dig_cnt     <= '0;
      cb          <= 1'b0;
      mode_q      <= 1'b0;
      b_out       <= 1'b0;
      b_out_valid <= 1'b0;
      digit_done  <= 1'b0;
      word_done   <= 1'b0;
      digit_err   <= 1'b0;
    end else begin
      b_out_valid <= 1'b0;
      digit_done  <= 1'b0;
      word_done   <= 1'b0;
      digit_err   <= 1'b0;
      if (frame_clr) begin
        bit_cnt <= 2'd0;
        dig_cnt <= '0;
        cb      <= 1'b0;
        b_out   <= 1'b0;
      end else if (b_valid) begin
        b_out       <= o_c;
        b_out_valid <= 1'b1;
        digit_done  <= last_c;
        word_done   <= last_c && (dig_cnt == LAST_DIG);
        digit_err   <= last_c && err_c;
        cb          <= cb_next_c;
        bit_cnt     <= bit_cnt + 2'd1;
        if (first_c)
          mode_q <= mode;
        if (last_c)
          dig_cnt <= (dig_cnt == LAST_DIG) ? '0 : dig_cnt + DCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_bcd_xs3_codec.sv
// Directed bench for serial_bcd_xs3_codec; one-digit and two-digit word instances share stimulus.
module tb_serial_bcd_xs3_codec;

  logic clk = 1'b0;
  logic reset, mode, b_valid, b_in, frame_clr;
  logic b_out1, v1, dd1, wd1, err1;
  logic b_out2, v2, dd2, wd2, err2;
  logic [4:0] obs1, obs2;
  int checks = 0;
  int errors = 0;

`ifdef SERIAL_BCD_XS3_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  serial_bcd_xs3_codec #(.DIGITS(1)) dut1 (
    .clk(clk), .reset(reset), .mode(mode), .b_valid(b_valid), .b_in(b_in),
    .frame_clr(frame_clr), .b_out(b_out1), .b_out_valid(v1), .digit_done(dd1),
    .word_done(wd1), .digit_err(err1));

  serial_bcd_xs3_codec #(.DIGITS(2)) dut2 (
    .clk(clk), .reset(reset), .mode(mode), .b_valid(b_valid), .b_in(b_in),
    .frame_clr(frame_clr), .b_out(b_out2), .b_out_valid(v2), .digit_done(dd2),
    .word_done(wd2), .digit_err(err2));

  assign obs1 = {b_out1, v1, dd1, wd1, err1};
  assign obs2 = {b_out2, v2, dd2, wd2, err2};

  always #5 clk = ~clk;

  // Drive one cycle of inputs and land 1 time unit after the capturing edge.
  task automatic drive(input logic v, input logic b, input logic m, input logic fc);
    @(negedge clk);
    b_valid = v; b_in = b; mode = m; frame_clr = fc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    b_valid = 1'b0; frame_clr = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 1'b0; b_valid = 1'b0; b_in = 1'b0; frame_clr = 1'b0;
    #2;
    checks++;
    if (obs1 !== 5'b0 || obs2 !== 5'b0) begin
      errors++; $display("FAIL reset_state got %b/%b want 00000/00000", obs1, obs2);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs1 !== 5'b0 || obs2 !== 5'b0) begin
      errors++; $display("FAIL reset_held got %b/%b want 00000/00000", obs1, obs2);
    end
    @(negedge clk);
    b_valid = 1'b0; reset = 1'b0;
  endtask

  // BCD 5 -> 8, then an idle cycle where b_out must hold.
  task automatic test_add_single();
    logic [3:0] din, dout;
    logic [4:0] e1, e2;
    logic last;
    din = 4'd5; dout = 4'd8;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, din[i], 1'b0, 1'b0);
      last = (i == 3);
      e1 = {dout[i], 1'b1, last, last, 1'b0};
      e2 = {dout[i], 1'b1, last, 1'b0, 1'b0};
      checks++;
      if (obs1 !== e1) begin errors++; $display("FAIL add5_d1 bit%0d got %b want %b", i, obs1, e1); end
      checks++;
      if (obs2 !== e2) begin errors++; $display("FAIL add5_d2 bit%0d got %b want %b", i, obs2, e2); end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs1 !== 5'b10000 || obs2 !== 5'b10000) begin
      errors++; $display("FAIL idle_hold got %b/%b want 10000/10000", obs1, obs2);
    end
  endtask

  // XS3 12 -> BCD 9; second digit of the two-digit word.
  task automatic test_sub_single();
    logic [3:0] din, dout;
    logic [4:0] e1, e2;
    logic last;
    din = 4'd12; dout = 4'd9;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, din[i], 1'b1, 1'b0);
      last = (i == 3);
      e1 = {dout[i], 1'b1, last, last, 1'b0};
      e2 = {dout[i], 1'b1, last, last, 1'b0};
      checks++;
      if (obs1 !== e1) begin errors++; $display("FAIL sub12_d1 bit%0d got %b want %b", i, obs1, e1); end
      checks++;
      if (obs2 !== e2) begin errors++; $display("FAIL sub12_d2 bit%0d got %b want %b", i, obs2, e2); end
    end
  endtask

  // Illegal digits: BCD 10 -> 13, XS3 2 -> 15.
  task automatic test_invalid();
    logic [3:0] din [2];
    logic [3:0] dout [2];
    logic       md [2];
    logic [4:0] e1, e2;
    logic last;
    din[0] = 4'd10; dout[0] = 4'd13; md[0] = 1'b0;
    din[1] = 4'd2;  dout[1] = 4'd15; md[1] = 1'b1;
    do_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, din[d][i], md[d], 1'b0);
        last = (i == 3);
        e1 = {dout[d][i], 1'b1, last, last, last & ERR_ON};
        e2 = {dout[d][i], 1'b1, last, last & (d == 1), last & ERR_ON};
        checks++;
        if (obs1 !== e1) begin errors++; $display("FAIL inv_d1 dig%0d bit%0d got %b want %b", d, i, obs1, e1); end
        checks++;
        if (obs2 !== e2) begin errors++; $display("FAIL inv_d2 dig%0d bit%0d got %b want %b", d, i, obs2, e2); end
      end
    end
  endtask

  // Word 0x37 -> XS3 A,6 with a 3-cycle gap before digit 0 bit 3.
  task automatic test_back_to_back();
    logic [3:0] din [2];
    logic [3:0] dout [2];
    logic [4:0] e1, e2;
    logic last;
    din[0] = 4'd7; dout[0] = 4'd10;
    din[1] = 4'd3; dout[1] = 4'd6;
    do_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        if (d == 0 && i == 3) begin
          for (int g = 0; g < 3; g++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0);
            e1 = {dout[0][2], 4'b0000};
            checks++;
            if (obs1 !== e1 || obs2 !== e1) begin
              errors++; $display("FAIL gap%0d got %b/%b want %b", g, obs1, obs2, e1);
            end
          end
        end
        drive(1'b1, din[d][i], 1'b0, 1'b0);
        last = (i == 3);
        e1 = {dout[d][i], 1'b1, last, last, 1'b0};
        e2 = {dout[d][i], 1'b1, last, last & (d == 1), 1'b0};
        checks++;
        if (obs1 !== e1) begin errors++; $display("FAIL word_d1 dig%0d bit%0d got %b want %b", d, i, obs1, e1); end
        checks++;
        if (obs2 !== e2) begin errors++; $display("FAIL word_d2 dig%0d bit%0d got %b want %b", d, i, obs2, e2); end
      end
    end
  endtask

  // Mid-digit frame_clr and mid-digit async reset, each followed by BCD 4 -> 7.
  task automatic test_restart();
    logic [3:0] din, dout;
    logic [4:0] e1, e2;
    logic last;
    din = 4'd4; dout = 4'd7;
    do_reset();
    for (int i = 0; i < 4; i++) drive(1'b1, ((i == 0) ? 1'b1 : 1'b0), 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs1[3:0] !== 4'b0 || obs2[3:0] !== 4'b0) begin
      errors++; $display("FAIL fclr_quiet got %b/%b want x0000/x0000", obs1, obs2);
    end
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (obs1 !== 5'b0 || obs2 !== 5'b0) begin
          errors++; $display("FAIL async_rst got %b/%b want 00000/00000", obs1, obs2);
        end
        @(negedge clk);
        b_valid = 1'b0;
        reset = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, din[i], 1'b0, 1'b0);
        last = (i == 3);
        e1 = {dout[i], 1'b1, last, last, 1'b0};
        e2 = {dout[i], 1'b1, last, 1'b0, 1'b0};
        checks++;
        if (obs1 !== e1) begin errors++; $display("FAIL restart%0d_d1 bit%0d got %b want %b", r, i, obs1, e1); end
        checks++;
        if (obs2 !== e2) begin errors++; $display("FAIL restart%0d_d2 bit%0d got %b want %b", r, i, obs2, e2); end
      end
    end
  endtask

  // Mode is latched on bit 0 only: BCD 2 stays an add; next digit subtracts XS3 5 -> 2.
  task automatic test_mode_latch();
    logic [3:0] din [2];
    logic [3:0] dout [2];
    logic [3:0] mbits [2];
    logic [4:0] e1, e2;
    logic last;
    din[0] = 4'd2; dout[0] = 4'd5; mbits[0] = 4'b1100;
    din[1] = 4'd5; dout[1] = 4'd2; mbits[1] = 4'b0001;
    do_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        drive(1'b1, din[d][i], mbits[d][i], 1'b0);
        last = (i == 3);
        e1 = {dout[d][i], 1'b1, last, last, 1'b0};
        e2 = {dout[d][i], 1'b1, last, last & (d == 1), 1'b0};
        checks++;
        if (obs1 !== e1) begin errors++; $display("FAIL mode_d1 dig%0d bit%0d got %b want %b", d, i, obs1, e1); end
        checks++;
        if (obs2 !== e2) begin errors++; $display("FAIL mode_d2 dig%0d bit%0d got %b want %b", d, i, obs2, e2); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_single();
    test_sub_single();
    test_invalid();
    test_back_to_back();
    test_restart();
    test_mode_latch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
